// File: rtl/vdiv_issuer.sv
// vdiv_issuer: splits a vector divide into element divides on a single-element
// divider, one element in flight at a time, and collects the quotient vector with lane flags.
module vdiv_issuer #(
  parameter  int EXP_WIDTH  = 8,
  parameter  int MANT_WIDTH = 7,
  parameter  int LANES      = 4,
  localparam int WIDTH      = EXP_WIDTH + MANT_WIDTH + 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [LANES*WIDTH-1:0] vec_a,
  input  logic [LANES*WIDTH-1:0] vec_b,
  output logic [WIDTH-1:0]       div_operand1,
  output logic [WIDTH-1:0]       div_operand2,
  output logic                   div_valid_in,
  input  logic                   div_ready_in,
  input  logic [WIDTH-1:0]       div_result,
  input  logic                   div_valid_out,
  output logic                   div_ready_out,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [LANES*WIDTH-1:0] vec_result,
  output logic [LANES-1:0]       dz_mask,
  output logic [LANES-1:0]       nan_mask
);

  localparam int               IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [IDX_W-1:0]       idx_r;
  logic [LANES*WIDTH-1:0] a_r;
  logic [LANES*WIDTH-1:0] b_r;
  logic [LANES*WIDTH-1:0] result_r;
  logic [LANES-1:0]       dz_r;
  logic [LANES-1:0]       nan_r;
  logic [LANES-1:0]       dz_s;

  function automatic logic is_nan(input logic [WIDTH-1:0] v);
    return (&v[WIDTH-2 -: EXP_WIDTH]) && (|v[MANT_WIDTH-1:0]);
  endfunction

  // Signed zero: every bit except the sign is clear
  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return ~(|v[WIDTH-2:0]);
  endfunction

  // Divide-by-zero flags of the incoming divisor vector
  always_comb begin
    dz_s = '0;
    for (int i = 0; i < LANES; i++) begin
      dz_s[i] = is_zero(vec_b[i*WIDTH +: WIDTH]);
    end
  end

  // Next-state decode of the issue sequencer
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) state_s = ISSUE;
        else           state_s = IDLE;
      end
      ISSUE: begin
        if (div_ready_in) state_s = WAIT;
        else              state_s = ISSUE;
      end
      WAIT: begin
        if (div_valid_out) begin
          if (idx_r == LAST_IDX) state_s = DONE;
          else                   state_s = ISSUE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE: begin
        if (resp_ready) state_s = IDLE;
        else            state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register plus operand latches, lane index and result collection
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= IDLE;
      idx_r    <= '0;
      a_r      <= '0;
      b_r      <= '0;
      result_r <= '0;
      dz_r     <= '0;
      nan_r    <= '0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            a_r      <= vec_a;
            b_r      <= vec_b;
            dz_r     <= dz_s;
            idx_r    <= '0;
            result_r <= '0;
            nan_r    <= '0;
          end
        end
        WAIT: begin
          // Quotient is stored bit-exact; only the NaN flag is derived from it
          if (div_valid_out) begin
            result_r[idx_r*WIDTH +: WIDTH] <= div_result;
            nan_r[idx_r]                   <= is_nan(div_result);
            if (idx_r != LAST_IDX) idx_r <= idx_r + 1'b1;
          end
        end
        ISSUE:   ;
        DONE:    ;
        default: ;
      endcase
    end
  end

  assign req_ready     = (state_r == IDLE);
  assign div_valid_in  = (state_r == ISSUE);
  assign div_ready_out = (state_r == WAIT);
  assign resp_valid    = (state_r == DONE);
  assign div_operand1  = a_r[idx_r*WIDTH +: WIDTH];
  assign div_operand2  = b_r[idx_r*WIDTH +: WIDTH];
  assign vec_result    = result_r;
  assign dz_mask       = dz_r;
  assign nan_mask      = nan_r;

endmodule

// File: tb/tb_vdiv_issuer.sv
// Bench for vdiv_issuer (BF16, 4 lanes): behavioural divider model on the negedge,
// issue-order and response scoreboards, stall / hold / abort scenarios.
module tb_vdiv_issuer;
  localparam int LANES = 4;
  localparam int W     = 16;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [LANES*W-1:0]   vec_a = '0;
  logic [LANES*W-1:0]   vec_b = '0;
  logic [W-1:0]         div_operand1, div_operand2;
  logic                 div_valid_in;
  logic                 div_ready_in = 1'b1;
  logic [W-1:0]         div_result = '0;
  logic                 div_valid_out = 1'b0;
  logic                 div_ready_out;
  logic                 resp_valid;
  logic                 resp_ready = 1'b0;
  logic [LANES*W-1:0]   vec_result;
  logic [LANES-1:0]     dz_mask, nan_mask;

  int n_checks = 0;
  int n_fail   = 0;

  // divider model state
  int          lat = 3, cnt = 0, stall_left = 0, in_cnt = 0, out_cnt = 0;
  bit          busy = 0, force_out = 0, model_clear = 0, stall_seen = 0;
  bit          in_pend = 0, out_pend = 0;
  logic [W-1:0] res_m = '0, cap1 = '0, cap2 = '0, hold1 = '0, hold2 = '0;
  logic [31:0]  iss_q[$];
  logic [71:0]  resp_q[$];

  vdiv_issuer #(.EXP_WIDTH(8), .MANT_WIDTH(7), .LANES(LANES)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .vec_a(vec_a), .vec_b(vec_b),
    .div_operand1(div_operand1), .div_operand2(div_operand2),
    .div_valid_in(div_valid_in), .div_ready_in(div_ready_in),
    .div_result(div_result), .div_valid_out(div_valid_out), .div_ready_out(div_ready_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .vec_result(vec_result), .dz_mask(dz_mask), .nan_mask(nan_mask)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Toy divider: exact for the cases the tests rely on, arbitrary token otherwise
  function automatic logic [15:0] bf_div(input logic [15:0] a, input logic [15:0] b);
    if (a[14:0] == 15'h0 && b[14:0] == 15'h0) return 16'h7FC0;
    else if (b[14:0] == 15'h0)                return {a[15] ^ b[15], 15'h7F80};
    else if (b == 16'h4000)                   return a - 16'h0080;
    else if (b == 16'h3F80)                   return a;
    else                                      return a ^ b ^ 16'h1234;
  endfunction

  function automatic logic bf_nan(input logic [15:0] v);
    return (v[14:7] == 8'hFF) && (v[6:0] != 7'h0);
  endfunction

  // Divider model: acts on the negedge, handshakes complete on the following posedge
  always @(negedge CLK) begin
    if (in_pend) begin
      in_cnt++;
      if (iss_q.size() == 0) check_val("issue_extra", 72'd1, 72'd0);
      else check_val("issue_order", {40'h0, cap1, cap2}, {40'h0, iss_q.pop_front()});
      busy  = 1;
      cnt   = lat;
      res_m = bf_div(cap1, cap2);
    end
    if (out_pend) begin
      out_cnt++;
      div_valid_out = 0;
      busy = 0;
    end
    if (model_clear) begin
      div_valid_out = 0;
      busy = 0;
    end
    if (busy && !div_valid_out) begin
      if (cnt <= 1 || force_out) begin
        div_valid_out = 1;
        div_result    = res_m;
      end else cnt--;
    end
    if (div_valid_in && stall_left > 0) begin
      if (stall_seen) begin
        check_val("stall_op1", {56'h0, div_operand1}, {56'h0, hold1});
        check_val("stall_op2", {56'h0, div_operand2}, {56'h0, hold2});
      end
      hold1 = div_operand1;
      hold2 = div_operand2;
      stall_seen = 1;
      stall_left--;
      div_ready_in = 0;
    end else begin
      stall_seen   = 0;
      div_ready_in = 1;
    end
    in_pend  = div_valid_in && div_ready_in && !RST;
    out_pend = div_valid_out && div_ready_out && !RST;
    cap1 = div_operand1;
    cap2 = div_operand2;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_req(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_v,
                        input logic [3:0] exp_dz, input logic [3:0] exp_nan,
                        input int stall, input int hold);
    logic [71:0] e;
    int n;
    for (int i = 0; i < LANES; i++) iss_q.push_back({a[i*W +: W], b[i*W +: W]});
    resp_q.push_back({exp_nan, exp_dz, exp_v});
    in_cnt = 0;
    out_cnt = 0;
    stall_left = stall;
    vec_a = a;
    vec_b = b;
    req_valid = 1;
    tick();
    check_val("accept", {71'h0, div_valid_in}, 72'd1);
    req_valid = 0;
    vec_a = {$urandom, $urandom};
    vec_b = {$urandom, $urandom};
    n = 0;
    while (!resp_valid && n < 200) begin
      tick();
      n++;
    end
    if (!resp_valid) begin
      check_val("resp_timeout", 72'd0, 72'd1);
    end else begin
      e = resp_q.pop_front();
      check_val("vec_result", {8'h0, vec_result}, {8'h0, e[63:0]});
      check_val("dz_mask", {68'h0, dz_mask}, {68'h0, e[67:64]});
      check_val("nan_mask", {68'h0, nan_mask}, {68'h0, e[71:68]});
      check_val("done_req_ready", {71'h0, req_ready}, 72'd0);
      for (int k = 0; k < hold; k++) begin
        req_valid = 1;
        vec_a = {$urandom, $urandom};
        tick();
        req_valid = 0;
        check_val("hold_valid", {71'h0, resp_valid}, 72'd1);
        check_val("hold_vec", {8'h0, vec_result}, {8'h0, e[63:0]});
        check_val("hold_masks", {64'h0, nan_mask, dz_mask}, {64'h0, e[71:64]});
        check_val("hold_req_ready", {71'h0, req_ready}, 72'd0);
      end
      resp_ready = 1;
      tick();
      resp_ready = 0;
      check_val("back_idle", {70'h0, req_ready, resp_valid}, 72'd2);
      check_val("in_hs", in_cnt, LANES);
      check_val("out_hs", out_cnt, LANES);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] a, b, ev;
    logic [3:0]  edz, enan;
    int n;
    repeat (2) @(posedge CLK);
    #1;
    RST = 0;
    check_val("rst_ctrl", {68'h0, req_ready, div_valid_in, div_ready_out, resp_valid}, 72'h8);
    check_val("rst_vec", {8'h0, vec_result}, 72'h0);
    check_val("rst_masks", {64'h0, nan_mask, dz_mask}, 72'h0);

    do_req(64'h4080_4040_4000_3F80, 64'h4000_4000_4000_4000, 64'h4000_3FC0_3F80_3F00,
           4'b0000, 4'b0000, 0, 0);
    do_req(64'h4100_40C0_4040_3F80, 64'h4000_4000_4000_4000, 64'h4080_4040_3FC0_3F00,
           4'b0000, 4'b0000, 5, 0);
    do_req(64'h4080_4040_0000_3F80, 64'h4000_8000_0000_4000, 64'h4000_FF80_7FC0_3F00,
           4'b0110, 4'b0010, 0, 10);
    do_req(64'h4000_0001_7F80_FFC1, 64'h0000_3F80_3F80_3F80, 64'h7F80_0001_7F80_FFC1,
           4'b1000, 4'b0001, 0, 0);

    for (int t = 0; t < 3; t++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      b[t*W +: W] = (t == 1) ? 16'h8000 : 16'h0000;
      b[(t+1)*W +: W] = 16'h4000;
      if (t == 2) a[W +: W] = 16'h7FA5;
      for (int i = 0; i < LANES; i++) begin
        ev[i*W +: W] = bf_div(a[i*W +: W], b[i*W +: W]);
        edz[i]  = (b[i*W +: 15] == 15'h0);
        enan[i] = bf_nan(ev[i*W +: W]);
      end
      do_req(a, b, ev, edz, enan, t, 0);
    end

    // abort in WAIT on lane 2, divider answers after the reset
    lat = 4;
    a = 64'h4080_4040_4000_3F80;
    b = 64'h0000_4000_4000_4000;
    for (int i = 0; i < LANES; i++) iss_q.push_back({a[i*W +: W], b[i*W +: W]});
    in_cnt = 0;
    out_cnt = 0;
    vec_a = a;
    vec_b = b;
    req_valid = 1;
    tick();
    req_valid = 0;
    n = 0;
    while (!(out_cnt == 2 && div_ready_out && busy) && n < 100) begin
      tick();
      n++;
    end
    check_val("abort_reach", {71'h0, (out_cnt == 2 && div_ready_out)}, 72'd1);
    RST = 1;
    tick();
    RST = 0;
    force_out = 1;
    check_val("abort_ctrl", {68'h0, req_ready, div_valid_in, div_ready_out, resp_valid}, 72'h8);
    check_val("abort_vec", {8'h0, vec_result}, 72'h0);
    check_val("abort_masks", {64'h0, nan_mask, dz_mask}, 72'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_val("abort_quiet", {69'h0, req_ready, div_ready_out, resp_valid}, 72'h4);
    end
    check_val("abort_nocap", out_cnt, 2);
    model_clear = 1;
    force_out = 0;
    tick();
    model_clear = 0;
    iss_q.delete();
    lat = 3;

    do_req(64'h4080_4040_4000_3F80, 64'h4000_4000_4000_4000, 64'h4000_3FC0_3F80_3F00,
           4'b0000, 4'b0000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vdiv_issuer.md
VDIV_ISSUER -- requirements
Module: vdiv_issuer

Interface
REQ-001 Parameter EXP_WIDTH, default 8, exponent bits (BF16: 8, FP16: 5).
REQ-002 Parameter MANT_WIDTH, default 7, mantissa bits (BF16: 7, FP16: 10); WIDTH = EXP_WIDTH+MANT_WIDTH+1.
REQ-003 Parameter LANES, default 4, elements per vector (range 1..16).
REQ-004 One clock; reset is synchronous and active-high: CLK input 1, rising-edge clock; RST input 1, synchronous active-high reset.
REQ-005 req_valid input 1, request vector pair present.
REQ-006 req_ready output 1, issuer can accept a request.
REQ-007 vec_a input LANES*WIDTH, dividend vector; lane i = bits [i*WIDTH +: WIDTH].
REQ-008 vec_b input LANES*WIDTH, divisor vector, same packing.
REQ-009 div_operand1 output WIDTH, dividend element to the divider.
REQ-010 div_operand2 output WIDTH, divisor element to the divider.
REQ-011 div_valid_in output 1, element pair valid toward the divider.
REQ-012 div_ready_in input 1, divider accepts the element pair.
REQ-013 div_result input WIDTH, divider quotient.
REQ-014 div_valid_out input 1, divider quotient valid.
REQ-015 div_ready_out output 1, issuer accepts the quotient.
REQ-016 resp_valid output 1, result vector valid.
REQ-017 resp_ready input 1, consumer accepts the result vector.
REQ-018 vec_result output LANES*WIDTH, quotient vector, same packing.
REQ-019 dz_mask output LANES, bit i set when vec_b lane i is +0 or -0.
REQ-020 nan_mask output LANES, bit i set when the captured quotient lane i is NaN (exponent all ones, mantissa nonzero).

Function
REQ-021 FSM states IDLE, ISSUE, WAIT, DONE; req_ready, div_valid_in, div_ready_out and resp_valid SHALL be decoded from the state register only (Moore).
REQ-022 IDLE: req_ready=1. When req_valid=1, latch vec_a, vec_b and dz_mask, clear lane index, clear nan_mask and vec_result, and go to ISSUE.
REQ-023 ISSUE: div_valid_in=1; div_operand1/2 = latched lane[index]. When div_ready_in=1, go to WAIT. Operands stay stable while the pair is unaccepted.
REQ-024 WAIT: div_ready_out=1. When div_valid_out=1, write div_result into vec_result lane[index] and set nan_mask[index]. If index==LANES-1, go to DONE; otherwise increment index and go to ISSUE.
REQ-025 DONE: resp_valid=1, with vec_result, dz_mask and nan_mask held stable. When resp_ready=1, go to IDLE.
REQ-026 Only one element is outstanding at a time. Lanes are issued strictly in order 0..LANES-1, with exactly LANES input handshakes and LANES output handshakes per request.
REQ-027 div_valid_out in IDLE, ISSUE or DONE is ignored (div_ready_out=0) and SHALL NOT alter state.
REQ-028 Quotient bits are captured unmodified; NaN payload and sign are passed through.
REQ-029 Minimum latency with a zero-wait divider is 2*LANES+1 cycles from request acceptance to resp_valid. A new request is accepted no earlier than 1 cycle after the response handshake.
REQ-030 The lane index width is clog2(LANES), minimum 1. The index SHALL never exceed LANES-1.
REQ-031 req_valid in non-IDLE states is ignored; latched vectors SHALL NOT change until the next IDLE acceptance.

Reset
REQ-032 RST=1 at a CLK edge forces IDLE and clears the index, vec_result, dz_mask and nan_mask to 0, regardless of state.
REQ-033 During and after reset: req_ready=1 only in IDLE; div_valid_in=0, div_ready_out=0, resp_valid=0.
REQ-034 Reset in ISSUE or WAIT abandons the request. A later divider response is not accepted.

Verification
REQ-035 Reset: hold RST for 2 cycles, then release -> req_ready=1, div_valid_in=0, resp_valid=0, vec_result=0, masks=0.
REQ-036 BF16, LANES=4, divider model with fixed 3-cycle latency: vec_a lanes {3F80,4000,4040,4080}, vec_b all 4000 -> vec_result lanes {3F00,3F80,3FC0,4000}, dz_mask=0, nan_mask=0, lanes issued in order, exactly 4 handshakes each side.
REQ-037 Divider holds div_ready_in=0 for 5 cycles in ISSUE -> div_valid_in stays 1 with div_operand1/2 unchanged each cycle; exactly one acceptance follows.
REQ-038 vec_b lane1=0000, lane2=8000, vec_a lane1=0000, model returns 7FC0 for 0/0 -> dz_mask=4'b0110, nan_mask=4'b0010, vec_result lane1=7FC0.
REQ-039 resp_ready=0 for 10 cycles in DONE -> resp_valid, vec_result and masks stable; req_ready=0; req_valid pulses are ignored.
REQ-040 RST asserted in WAIT lane 2, model raises div_valid_out 1 cycle later -> IDLE next cycle, div_ready_out=0, no capture, resp_valid never asserted for the aborted request.
